// File: rtl/led_cnt_pkg.sv
// ============================================================================
// led_cnt_pkg : shared types and constants for the multi-channel LED counter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package led_cnt_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FROZEN = 2'd2
  } dfx_state_t;

  localparam mode_t MODE_RESET = MODE_BLINK;
  localparam int    CH_IDX_W   = 4;

endpackage

`default_nettype wire

// File: rtl/led_cnt_chan.sv
// ============================================================================
// led_cnt_chan : one LED channel - mode/div registers, divider, blink, decode
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module led_cnt_chan
  import led_cnt_pkg::*;
#(
  parameter int CNT_W       = 27,
  parameter int PWM_W       = 8,
  parameter int DIV_DEFAULT = 50000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  mode_t            wr_mode,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [PWM_W-1:0] ramp,
  output logic             led
);

  mode_t            mode;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             blink_q;
  logic             led_nxt;

  always_comb begin
    led_nxt = 1'b0;
    case (mode)
      MODE_OFF:   led_nxt = 1'b0;
      MODE_ON:    led_nxt = 1'b1;
      MODE_BLINK: led_nxt = blink_q;
      MODE_PWM:   led_nxt = (ramp < div[PWM_W-1:0]);
      default:    led_nxt = 1'b0;
    endcase
  end

  // Writes are only issued in RUN, so clr/wr never collide with a frozen channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode    <= MODE_RESET;
      div     <= CNT_W'(DIV_DEFAULT);
      cnt     <= '0;
      blink_q <= 1'b0;
      led     <= 1'b0;
    end else begin
      if (wr) begin
        mode <= wr_mode;
        div  <= wr_div;
      end
      if (clr) begin
        cnt     <= '0;
        blink_q <= 1'b0;
      end else if (en) begin
        if (cnt == div) begin
          cnt     <= '0;
          blink_q <= ~blink_q;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (en) begin
        led <= led_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_cnt_multi.sv
// ============================================================================
// led_cnt_multi : N-channel LED counter with per-channel mode and DFX freeze
// Optional: define LED_CNT_PHASE_SYNC_EN to clear every channel on any write
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module led_cnt_multi
  import led_cnt_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 27,
  parameter int DIV_DEFAULT = 50000000,
  parameter int PWM_W       = 8
) (
  input  logic                clk100,
  input  logic                rstn,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_err,
  input  logic                decouple_req,
  output logic                decouple_ack,
  output logic [N_CH-1:0]     leds_o
);

  dfx_state_t       state;
  dfx_state_t       state_nxt;
  logic             run_en;
  logic             ch_ok;
  logic             accept;
  logic [PWM_W-1:0] ramp;

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (decouple_req) state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = decouple_req ? ST_FROZEN : ST_RUN;
      ST_FROZEN: if (!decouple_req) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // ack is decoded from the state register, so it drops on the same edge FROZEN is left.
  always_comb begin
    run_en       = (state == ST_RUN);
    decouple_ack = (state == ST_FROZEN);
  end

  assign ch_ok  = ({1'b0, cfg_ch} < (CH_IDX_W + 1)'(N_CH));
  assign accept = cfg_we && run_en && ch_ok;

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      cfg_err <= 1'b0;
      ramp    <= '0;
    end else begin
      cfg_err <= cfg_we && !(run_en && ch_ok);
      if (run_en) begin
        ramp <= ramp + PWM_W'(1);
      end
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      logic wr;
      logic clr;

      assign wr = accept && (cfg_ch == CH_IDX_W'(i));
`ifdef LED_CNT_PHASE_SYNC_EN
      assign clr = accept;
`else
      assign clr = wr;
`endif

      led_cnt_chan #(
        .CNT_W       (CNT_W),
        .PWM_W       (PWM_W),
        .DIV_DEFAULT (DIV_DEFAULT)
      ) u_chan (
        .clk     (clk100),
        .rstn    (rstn),
        .en      (run_en),
        .clr     (clr),
        .wr      (wr),
        .wr_mode (mode_t'(cfg_mode)),
        .wr_div  (cfg_div),
        .ramp    (ramp),
        .led     (leds_o[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_cnt_multi.sv
// ============================================================================
// tb_led_cnt_multi : directed scoreboard bench for led_cnt_multi
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_cnt_multi;

  localparam int N_CH        = 2;
  localparam int CNT_W       = 27;
  localparam int DIV_DEFAULT = 4;
  localparam int PWM_W       = 8;

  logic             clk100 = 1'b0;
  logic             rstn = 1'b0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_err;
  logic             decouple_req = 1'b0;
  logic             decouple_ack;
  logic [N_CH-1:0]  leds_o;

  always #5 clk100 = ~clk100;

  led_cnt_multi #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT),
    .PWM_W       (PWM_W)
  ) dut (
    .clk100       (clk100),
    .rstn         (rstn),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_div      (cfg_div),
    .cfg_err      (cfg_err),
    .decouple_req (decouple_req),
    .decouple_ack (decouple_ack),
    .leds_o       (leds_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   k      = 0;
  int   ones   = 0;

  // Blink level visible on leds_o after n running edges since the last clear.
  function automatic logic blink_at(input int n);
    if (n < 1) return 1'b0;
    return logic'(((n - 1) / (DIV_DEFAULT + 1)) % 2);
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic drive_write(input int ch, input int mode, input int div);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_mode = 2'(mode);
    cfg_div  = CNT_W'(div);
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    expect_val("reset_leds", 0); check_out(32'(leds_o));
    expect_val("reset_ack", 0);  check_out(32'(decouple_ack));
    expect_val("reset_err", 0);  check_out(32'(cfg_err));

    // Default blink, both channels in phase
    rstn = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      step(); k++;
      expect_val("t1_blink", 32'({blink_at(k), blink_at(k)}));
      check_out(32'(leds_o));
    end

    // Decouple: the RUN->HOLD edge still counts, then everything freezes
    decouple_req = 1'b1;
    step(); k++;
    expect_val("t4_ack_hold", 0); check_out(32'(decouple_ack));
    expect_val("t4_leds_hold", 32'({blink_at(k), blink_at(k)})); check_out(32'(leds_o));
    step();
    expect_val("t4_ack_frozen", 1); check_out(32'(decouple_ack));
    drive_write(0, 1, 0);
    expect_val("t4_err_frozen", 1); check_out(32'(cfg_err));
    expect_val("t4_leds_frozen", 32'({blink_at(k), blink_at(k)})); check_out(32'(leds_o));
    step();
    expect_val("t4_err_pulse_end", 0); check_out(32'(cfg_err));
    for (int i = 0; i < 5; i++) begin
      step();
      expect_val("t4_leds_frozen", 32'({blink_at(k), blink_at(k)}));
      check_out(32'(leds_o));
    end
    decouple_req = 1'b0;
    step();
    expect_val("t4_ack_drop", 0); check_out(32'(decouple_ack));
    for (int i = 0; i < 12; i++) begin
      step(); k++;
      expect_val("t4_resume", 32'({blink_at(k), blink_at(k)}));
      check_out(32'(leds_o));
    end

    // ch1 BLINK div=0: toggles every cycle, ch0 keeps its phase
    drive_write(1, 2, 0); k++;
    expect_val("t2_err", 0); check_out(32'(cfg_err));
    expect_val("t2_write_edge", 32'({blink_at(k), blink_at(k)})); check_out(32'(leds_o));
    for (int j = 1; j <= 10; j++) begin
      step(); k++;
      expect_val("t2_fast_blink", 32'({logic'(j % 2 == 0), blink_at(k)}));
      check_out(32'(leds_o));
    end

    // ch0 ON visible two cycles after the write strobe
    drive_write(0, 1, 0);
    step();
    expect_val("t3_on", 1); check_out(32'(leds_o[0]));

    // ch0 PWM duty 64 over one full ramp period
    drive_write(0, 3, 64);
    step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      ones += int'(leds_o[0]);
      step();
    end
    expect_val("t3_pwm64_ones", 64); check_out(32'(ones));

    drive_write(0, 3, 0);
    step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      ones += int'(leds_o[0]);
      step();
    end
    expect_val("t3_pwm0_ones", 0); check_out(32'(ones));

    // Out-of-range channel writes rejected
    drive_write(0, 1, 0);
    drive_write(1, 0, 0);
    step();
    expect_val("t5_setup", 32'h1); check_out(32'(leds_o));
    drive_write(5, 1, 0);
    expect_val("t5_err_ch5", 1); check_out(32'(cfg_err));
    step();
    expect_val("t5_err_end", 0); check_out(32'(cfg_err));
    expect_val("t5_leds_same", 32'h1); check_out(32'(leds_o));
    drive_write(2, 1, 0);
    expect_val("t5_err_ch2", 1); check_out(32'(cfg_err));
    step();
    expect_val("t5_leds_same2", 32'h1); check_out(32'(leds_o));

    // Write coinciding with decouple request in RUN is accepted
    cfg_we = 1'b1; cfg_ch = 4'd1; cfg_mode = 2'd1; cfg_div = '0;
    decouple_req = 1'b1;
    step();
    cfg_we = 1'b0;
    expect_val("t4_simul_err", 0); check_out(32'(cfg_err));
    step();
    expect_val("t4_simul_ack", 1); check_out(32'(decouple_ack));
    expect_val("t4_simul_frozen", 32'h1); check_out(32'(leds_o));
    decouple_req = 1'b0;
    step();
    step();
    expect_val("t4_simul_applied", 32'h3); check_out(32'(leds_o));

    // Reset while frozen with LEDs lit
    decouple_req = 1'b1;
    step(); step();
    expect_val("t6_frozen_ack", 1); check_out(32'(decouple_ack));
    #2 rstn = 1'b0;
    #1;
    expect_val("t6_async_leds", 0); check_out(32'(leds_o));
    expect_val("t6_async_ack", 0);  check_out(32'(decouple_ack));
    decouple_req = 1'b0;
    step();
    rstn = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step(); k++;
    end
    expect_val("t6_restart_blink", 32'({blink_at(k), blink_at(k)})); check_out(32'(leds_o));
    expect_val("t6_run_ack", 0); check_out(32'(decouple_ack));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_cnt_multi.md
Name: led_cnt_multi

Overview:
- Parametrised successor to the fixed two-output LED counter top.
- Drives N_CH LED outputs. Each channel has its own runtime-configurable mode (off/on/blink/PWM dim) and divide ratio.
- Adds a DFX-style decouple handshake. While a partition is reconfigured, all channels freeze, outputs hold, and configuration is locked.
- Sits between the PS/config register bank and the board LED pins.

Parameters:
- N_CH, 2, number of LED channels (1..16)
- CNT_W, 27, width of per-channel divide counter and divide register
- DIV_DEFAULT, 50000000, reset divide value (blink toggles every DIV_DEFAULT+1 cycles)
- PWM_W, 8, width of the shared PWM ramp and of the duty field

Ports:
- clk100  in  1  system clock, 100 MHz; all logic in this domain
- rstn  in  1  asynchronous active-low reset
- cfg_we  in  1  one-cycle config write strobe
- cfg_ch  in  4  target channel index
- cfg_mode  in  2  mode for target channel: 0 OFF, 1 ON, 2 BLINK, 3 PWM
- cfg_div  in  CNT_W  divide value (BLINK); low PWM_W bits are duty (PWM)
- cfg_err  out  1  one-cycle pulse: write rejected
- decouple_req  in  1  request freeze for reconfiguration (level)
- decouple_ack  out  1  freeze in effect (level)
- leds_o  out  N_CH  LED drive, active high

Behaviour:
- Clock and reset: one clock, clk100; reset is asynchronous and active-low (rstn).
- Reset values:
  - leds_o = 0, cfg_err = 0, decouple_ack = 0
  - all modes = BLINK, all div = DIV_DEFAULT
  - all counters, blink states and PWM ramp = 0
  - FSM = RUN
- Per channel (RUN state only):
  - cnt increments each cycle. When cnt == div, cnt wraps to 0 and blink_q toggles. div = 0 gives a toggle every cycle.
  - div is unsigned CNT_W bits. cnt never exceeds div.
- Shared PWM ramp: PWM_W-bit free-running counter that wraps 2^PWM_W-1 -> 0 and halts outside RUN.
- Output decode, registered (leds_o changes 1 cycle after the driving state):
  - OFF -> 0
  - ON -> 1
  - BLINK -> blink_q
  - PWM -> (ramp < duty); duty 0 gives always 0
- Config write (cfg_we=1, FSM=RUN, cfg_ch < N_CH):
  - mode/div of cfg_ch update on the next edge.
  - That channel's cnt and blink_q clear to 0 on the same edge.
  - The new mode is visible on leds_o 2 cycles after cfg_we.
- Rejected write (cfg_ch >= N_CH, or FSM != RUN): no state change; cfg_err pulses high the following cycle.
- Decouple FSM:
  - RUN: decouple_req=1 -> HOLD.
  - HOLD: counters, ramp and leds_o frozen; ack=0. If req=1 -> FROZEN; if req=0 -> RUN.
  - FROZEN: everything frozen; ack=1. If req=0 -> RUN, and ack drops on that same edge.
  - req -> ack latency is 2 cycles. Counting resumes from the held values; there is no phase reset.
- Simultaneous cfg_we and decouple_req rising in RUN: the write is accepted (FSM still RUN that cycle).
- Reset mid-operation (any state): immediate return to reset values, including dropping decouple_ack.

Optional Feature:
- Macro: LED_CNT_PHASE_SYNC_EN.
- Defined: any accepted config write clears cnt and blink_q of ALL channels, so blinking channels stay phase aligned.
- Undefined: only the addressed channel clears.

Decomposition:
- Package led_cnt_pkg holds:
  - mode_t enum (OFF/ON/BLINK/PWM, 2 bits)
  - dfx_state_t enum (RUN/HOLD/FROZEN)
  - MODE_RESET constant
  - CH_IDX_W = 4
- Sub-module led_cnt_chan, one per channel via generate. It contains the mode/div registers, divide counter, blink_q and output decode. Inputs: en, clr, wr, ramp.
- The top keeps the FSM, shared ramp, address decode and cfg_err.

Test Plan:
1. Reset then release, N_CH=2, DIV_DEFAULT=4 -> both leds_o toggle every 5 cycles, in phase; first toggle visible 6 cycles after rstn rises.
2. Write ch1 BLINK div=0 -> leds_o[1] toggles every cycle starting 3 cycles after cfg_we; ch0 unaffected (phase-sync macro undefined).
3. Write ch0 PWM duty=64, PWM_W=8 -> leds_o[0] high for exactly 64 of every 256 cycles. Duty=0 -> stays 0.
4. Assert decouple_req -> ack=1 after 2 cycles; leds_o and counters frozen. A write issued during FROZEN gives cfg_err pulse and no change. Drop req -> ack=0 next cycle and counting resumes from the held value.
5. Write cfg_ch=5 with N_CH=2 -> cfg_err high 1 cycle, all outputs unchanged.
6. Assert rstn low during FROZEN with one LED on -> leds_o=0 and ack=0 asynchronously; FSM is RUN after release.
